// File: rtl/seg7_to_nibble_capture.sv
// Debounces a multiplexed active-low 7-segment bus, decodes each digit back to
// a nibble and hands changed digits out through a one-entry valid/ready slot.
module seg7_to_nibble_capture #(
    parameter int DIGIT_W       = 2,
    parameter int STABLE_CYCLES = 4,
    localparam int DIGITS       = 2**DIGIT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            hex_in,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIGIT_W-1:0]    out_digit,
    output logic [3:0]            out_nibble,
    output logic                  out_err,
    output logic [4*DIGITS-1:0]   snapshot,
    output logic [7:0]            drop_cnt
);
    localparam logic [3:0] S = 4'(STABLE_CYCLES);

    typedef enum logic {EMPTY, FULL} state_t;

    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'h3F: decode = 5'h00;  7'h06: decode = 5'h01;
            7'h5B: decode = 5'h02;  7'h4F: decode = 5'h03;
            7'h66: decode = 5'h04;  7'h6D: decode = 5'h05;
            7'h7D: decode = 5'h06;  7'h07: decode = 5'h07;
            7'h7F: decode = 5'h08;  7'h67: decode = 5'h09;
            7'h77: decode = 5'h0A;  7'h7C: decode = 5'h0B;
            7'h39: decode = 5'h0C;  7'h5E: decode = 5'h0D;
            7'h79: decode = 5'h0E;  7'h71: decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction

    logic [6:0]              r_hex;
    logic [DIGITS-1:0]       r_sel;
    logic [3:0]              r_run;
    logic                    r_hit;
    state_t                  r_state;
    logic [DIGIT_W-1:0]      r_digit;
    logic [3:0]              r_nib;
    logic                    r_err;
    logic [4*DIGITS-1:0]     r_snap;
    logic [7:0]              r_drop;
    logic [DIGITS-1:0]       r_seen;
    logic [DIGITS-1:0][4:0]  r_stored;

    logic                    w_onehot;
    logic                    w_same;
    logic [3:0]              w_run_nxt;
    logic [DIGIT_W-1:0]      w_idx;
    logic [4:0]              w_dec;
    logic                    w_emit;
    logic                    w_drain;
    logic                    w_load;
    logic                    w_drop;
    state_t                  w_state_nxt;

    assign w_onehot = $onehot(dig_sel);
    assign w_same   = ({dig_sel, hex_in} == {r_sel, r_hex});

    always_comb begin
        w_run_nxt = 4'd0;
        if (w_onehot && w_same)
            w_run_nxt = (r_run == S) ? S : r_run + 4'd1;
        else if (w_onehot)
            w_run_nxt = 4'd1;
    end

    // r_hit marks the capture edge; the sample registers still hold that
    // capture's data on the following edge, where it is filtered and emitted.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < DIGITS; i++)
            if (r_sel[i]) w_idx = DIGIT_W'(i);
    end

    assign w_dec   = decode(~r_hex);
    assign w_emit  = r_hit && (!r_seen[w_idx] || (r_stored[w_idx] != w_dec));
    assign w_drain = out_valid && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            EMPTY: if (w_emit) begin
                w_state_nxt = FULL;
                w_load      = 1'b1;
            end
            FULL: begin
                if (w_emit && w_drain) w_load = 1'b1;
                else if (w_emit)       w_drop = 1'b1;
                else if (w_drain)      w_state_nxt = EMPTY;
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= EMPTY;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hex    <= '0;
            r_sel    <= '0;
            r_run    <= '0;
            r_hit    <= 1'b0;
            r_digit  <= '0;
            r_nib    <= '0;
            r_err    <= 1'b0;
            r_snap   <= '0;
            r_drop   <= '0;
            r_seen   <= '0;
            r_stored <= '0;
        end else begin
            r_hex <= hex_in;
            r_sel <= dig_sel;
            r_run <= w_run_nxt;
            r_hit <= (w_run_nxt == S) && (r_run != S);
            if (w_load) begin
                r_digit <= w_idx;
                r_nib   <= w_dec[3:0];
                r_err   <= w_dec[4];
            end
            if (w_drop && r_drop != 8'hFF)
                r_drop <= r_drop + 8'd1;
            if (w_emit) begin
                r_seen[w_idx]   <= 1'b1;
                r_stored[w_idx] <= w_dec;
                if (!w_dec[4])
                    r_snap[4*w_idx +: 4] <= w_dec[3:0];
            end
        end
    end

    assign out_valid  = (r_state == FULL);
    assign out_digit  = r_digit;
    assign out_nibble = r_nib;
    assign out_err    = r_err;
    assign snapshot   = r_snap;
    assign drop_cnt   = r_drop;
endmodule

// File: tb/tb_seg7_to_nibble_capture.sv
// Directed bench: a behavioural model (run lengths, glyph lookup, slot) is
// compared every cycle, plus literal expectations at the key edges.
module tb_seg7_to_nibble_capture;
    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  hex_in = 7'h7F;
    logic [3:0]  dig_sel = 4'b0000;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [1:0]  out_digit;
    logic [3:0]  out_nibble;
    logic        out_err;
    logic [15:0] snapshot;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int failures = 0;

    seg7_to_nibble_capture #(.DIGIT_W(2), .STABLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .hex_in(hex_in), .dig_sel(dig_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
        .out_nibble(out_nibble), .out_err(out_err), .snapshot(snapshot),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0]  glyph [16];
    initial begin
        glyph[0]  = 7'h3F; glyph[1]  = 7'h06; glyph[2]  = 7'h5B; glyph[3]  = 7'h4F;
        glyph[4]  = 7'h66; glyph[5]  = 7'h6D; glyph[6]  = 7'h7D; glyph[7]  = 7'h07;
        glyph[8]  = 7'h7F; glyph[9]  = 7'h67; glyph[10] = 7'h77; glyph[11] = 7'h7C;
        glyph[12] = 7'h39; glyph[13] = 7'h5E; glyph[14] = 7'h79; glyph[15] = 7'h71;
    end

    int          run_len;
    logic [10:0] last;
    logic        pend;
    int          pend_d;
    logic [6:0]  pend_hex;
    logic        m_valid, m_err;
    int          m_digit, m_nib, m_drop;
    logic [15:0] m_snap;
    logic [3:0]  m_seen;
    int          m_val [4];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            run_len = 0; last = '0; pend = 0; pend_d = 0; pend_hex = '0;
            m_valid = 0; m_err = 0; m_digit = 0; m_nib = 0; m_drop = 0;
            m_snap = '0; m_seen = '0;
            for (int i = 0; i < 4; i++) m_val[i] = 0;
        end else begin
            logic drain, emit, e;
            int n, code;
            drain = m_valid && out_ready;
            emit = 0;
            if (pend) begin
                e = 1; n = 0;
                for (int i = 0; i < 16; i++)
                    if (glyph[i] == ~pend_hex) begin e = 0; n = i; end
                code = e ? 16 : n;
                emit = !m_seen[pend_d] || m_val[pend_d] != code;
                if (emit) begin
                    m_seen[pend_d] = 1;
                    m_val[pend_d] = code;
                    if (!e) m_snap[4*pend_d +: 4] = 4'(n);
                end
            end
            if (emit && (!m_valid || drain)) begin
                m_valid = 1; m_digit = pend_d; m_nib = n; m_err = e;
            end else if (emit) begin
                if (m_drop < 255) m_drop++;
            end else if (drain) m_valid = 0;

            if ($countones(dig_sel) == 1 && {dig_sel, hex_in} == last) run_len++;
            else if ($countones(dig_sel) == 1) run_len = 1;
            else run_len = 0;
            pend = (run_len == S);
            if (pend) begin
                pend_hex = hex_in;
                for (int i = 0; i < 4; i++) if (dig_sel[i]) pend_d = i;
            end
            last = {dig_sel, hex_in};
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("mdl_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("mdl_digit", 32'(out_digit), 32'(m_digit));
                chk("mdl_nibble", 32'(out_nibble), 32'(m_nib));
                chk("mdl_err", 32'(out_err), 32'(m_err));
            end
            chk("mdl_snapshot", 32'(snapshot), 32'(m_snap));
            chk("mdl_drop", 32'(drop_cnt), 32'(m_drop));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin @(posedge clk); @(negedge clk); end
    endtask

    task automatic drive(input logic [3:0] sel, input logic [6:0] seg);
        dig_sel = sel; hex_in = ~seg;
    endtask

    task automatic count_valid(input int n, output int v);
        v = 0;
        repeat (n) begin step(1); if (out_valid) v++; end
    endtask

    initial begin
        int v;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_snapshot", 32'(snapshot), 0);
        rst = 1'b0;
        step(2);

        // basic capture: emit appears exactly at edge S+1
        drive(4'b0010, 7'h5B);
        step(S);
        chk("basic_early", 32'(out_valid), 0);
        step(1);
        chk("basic_valid", 32'(out_valid), 1);
        chk("basic_digit", 32'(out_digit), 1);
        chk("basic_nibble", 32'(out_nibble), 2);
        chk("basic_err", 32'(out_err), 0);
        chk("basic_snap", 32'(snapshot[7:4]), 2);
        count_valid(5, v);
        chk("basic_once", 32'(v), 0);

        // glitch: three samples only
        drive(4'b0001, 7'h06);
        step(3);
        drive(4'b0000, 7'h06);
        count_valid(6, v);
        chk("glitch_none", 32'(v), 0);

        // error glyph on digit 3
        drive(4'b1000, 7'h40);
        step(S + 1);
        chk("err_valid", 32'(out_valid), 1);
        chk("err_flag", 32'(out_err), 1);
        chk("err_nibble", 32'(out_nibble), 0);
        chk("err_digit", 32'(out_digit), 3);
        chk("err_snap", 32'(snapshot[15:12]), 0);
        drive(4'b0000, 7'h00);
        step(3);

        // change filter
        drive(4'b0001, 7'h3F);
        step(S + 1);
        chk("filt_first", 32'(out_valid), 1);
        drive(4'b0000, 7'h3F);
        count_valid(2, v);
        drive(4'b0001, 7'h3F);
        begin
            int v2;
            count_valid(6, v2);
            chk("filt_repeat", 32'(v + v2), 0);
        end
        drive(4'b0001, 7'h71);
        step(S + 1);
        chk("filt_F_valid", 32'(out_valid), 1);
        chk("filt_F_nibble", 32'(out_nibble), 4'hF);
        step(1);

        // backpressure: second capture dropped
        out_ready = 1'b0;
        drive(4'b0000, 7'h00);
        step(2);
        drive(4'b0001, 7'h07);
        step(S + 1);
        chk("bp_first", 32'(out_nibble), 7);
        drive(4'b0010, 7'h77);
        step(S + 1);
        chk("bp_drop", 32'(drop_cnt), 1);
        chk("bp_hold_digit", 32'(out_digit), 0);
        chk("bp_hold_nibble", 32'(out_nibble), 7);
        chk("bp_snap", 32'(snapshot[7:0]), 32'h A7);

        // drain and emit on the same edge
        drive(4'b0100, 7'h66);
        step(S);
        out_ready = 1'b1;
        step(1);
        chk("same_valid", 32'(out_valid), 1);
        chk("same_digit", 32'(out_digit), 2);
        chk("same_nibble", 32'(out_nibble), 4);
        chk("same_drop", 32'(drop_cnt), 1);
        out_ready = 1'b0;

        // drop counter saturation
        for (int k = 0; k < 300; k++) begin
            drive(4'b0001, (k % 2 == 0) ? 7'h06 : 7'h5B);
            step(S);
        end
        step(2);
        chk("sat_drop", 32'(drop_cnt), 255);
        chk("sat_hold_digit", 32'(out_digit), 2);
        chk("sat_hold_nibble", 32'(out_nibble), 4);

        // asynchronous reset with the slot full
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_digit", 32'(out_digit), 0);
        chk("arst_nibble", 32'(out_nibble), 0);
        chk("arst_err", 32'(out_err), 0);
        chk("arst_snap", 32'(snapshot), 0);
        chk("arst_drop", 32'(drop_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        step(S);
        chk("rerun_early", 32'(out_valid), 0);
        step(1);
        chk("rerun_valid", 32'(out_valid), 1);
        chk("rerun_nibble", 32'(out_nibble), 2);
        chk("rerun_snap", 32'(snapshot), 2);
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
